// File: rtl/adjust_sequencer.sv
// -----------------------------------------------------------------------------
// adjust_sequencer
//
// Front-end controller for adjust_inc_control. Turns two debounced buttons
// into a one-hot field selector and a single-cycle increment strobe.
//   - mode press steps RUN -> HOURS -> MINUTES -> SECONDS -> RUN
//   - inc press emits one strobe; holding inc auto-repeats after HOLD_TICKS,
//     then every REPEAT_TICKS
//   - inactivity for TIMEOUT_TICKS forces a return to RUN
//   - blink flashes the field being edited (1 = visible)
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous, active-low reset
//   btn_mode         debounced mode button level, 1 = pressed
//   btn_inc          debounced increment button level, 1 = pressed
//   adjust_mode[2:0] one-hot field select: bit2 hours, bit1 minutes,
//                    bit0 seconds, 000 = RUN
//   adjust_increment registered single-cycle increment strobe
//   blink            display phase, 1 = field visible
//   adjusting        high in any non-RUN state
// -----------------------------------------------------------------------------
module adjust_sequencer #(
  parameter int TICK_DIV      = 50000,
  parameter int HOLD_TICKS    = 500,
  parameter int REPEAT_TICKS  = 100,
  parameter int TIMEOUT_TICKS = 10000,
  parameter int BLINK_TICKS   = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [2:0] adjust_mode,
  output logic       adjust_increment,
  output logic       blink,
  output logic       adjusting
);

  localparam int TICK_W   = $clog2(TICK_DIV);
  localparam int HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int TO_W     = $clog2(TIMEOUT_TICKS + 1);
  localparam int BLINK_W  = $clog2(BLINK_TICKS + 1);

  // State encoding doubles as the adjust_mode output.
  typedef enum logic [2:0] {
    ST_RUN     = 3'b000,
    ST_HOURS   = 3'b100,
    ST_MINUTES = 3'b010,
    ST_SECONDS = 3'b001
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [TICK_W-1:0]   r_tick_cnt;
  logic                r_mode_prev;
  logic                r_inc_prev;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_rep_armed;
  logic                r_rep_phase;   // 0: waiting for first hold, 1: repeating
  logic [TO_W-1:0]     r_timeout;
  logic                r_inc_pulse;
  logic                r_blink;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_adjusting;

  logic                w_tick;
  logic                w_mode_press;
  logic                w_inc_press;
  logic                w_in_adjust;
  logic                w_inc_start;
  logic                w_hold_last;
  logic                w_rep_pulse;
  logic                w_timeout;

  // ---------------------------------------------------------------------------
  // Free-running tick prescaler
  // ---------------------------------------------------------------------------
  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Press detection. Previous levels reset to 1 so a button held through
  // reset must be released before it can register a press.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_prev <= 1'b1;
      r_inc_prev  <= 1'b1;
    end else begin
      r_mode_prev <= btn_mode;
      r_inc_prev  <= btn_inc;
    end
  end

  assign w_mode_press = btn_mode & ~r_mode_prev;
  assign w_inc_press  = btn_inc  & ~r_inc_prev;
  assign w_in_adjust  = (r_state != ST_RUN);

  // A mode press in the same cycle swallows the inc press.
  assign w_inc_start  = w_inc_press & w_in_adjust & ~w_mode_press;

  // ---------------------------------------------------------------------------
  // Auto-repeat: the hold counter counts ticks while armed; its target is
  // HOLD_TICKS before the first repeat and REPEAT_TICKS afterwards.
  // ---------------------------------------------------------------------------
  assign w_hold_last = r_rep_phase ? (r_hold_cnt == HOLD_W'(REPEAT_TICKS - 1))
                                   : (r_hold_cnt == HOLD_W'(HOLD_TICKS - 1));

  assign w_rep_pulse = r_rep_armed & btn_inc & w_tick & w_hold_last & ~w_mode_press;

  // Expiry happens on the tick that takes the counter to zero, unless some
  // activity reloads it in that same cycle.
  assign w_timeout = w_in_adjust & w_tick & (r_timeout <= TO_W'(1)) &
                     ~w_mode_press & ~w_inc_press & ~w_rep_pulse;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_armed <= 1'b0;
      r_rep_phase <= 1'b0;
      r_hold_cnt  <= '0;
    end else if (w_mode_press || w_timeout || !btn_inc || !w_in_adjust) begin
      // Field change, timeout or release cancels the repeat until a new press.
      r_rep_armed <= 1'b0;
      r_rep_phase <= 1'b0;
      r_hold_cnt  <= '0;
    end else if (w_inc_start) begin
      r_rep_armed <= 1'b1;
      r_rep_phase <= 1'b0;
      r_hold_cnt  <= '0;
    end else if (r_rep_armed && w_tick) begin
      if (w_hold_last) begin
        r_rep_phase <= 1'b1;
        r_hold_cnt  <= '0;
      end else begin
        r_hold_cnt  <= r_hold_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inc_pulse <= 1'b0;
    end else begin
      r_inc_pulse <= w_inc_start | w_rep_pulse;
    end
  end

  // ---------------------------------------------------------------------------
  // Inactivity timeout
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout <= '0;
    end else if (w_mode_press || w_inc_press || w_rep_pulse) begin
      r_timeout <= TO_W'(TIMEOUT_TICKS);
    end else if (w_in_adjust && w_tick && (r_timeout != '0)) begin
      r_timeout <= r_timeout - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_adjusting <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_adjusting <= (w_next_state != ST_RUN);
    end
  end

  // NOTE: the default assignment comes first so every path drives
  // w_next_state and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (w_mode_press) begin
      case (r_state)
        ST_RUN:     w_next_state = ST_HOURS;
        ST_HOURS:   w_next_state = ST_MINUTES;
        ST_MINUTES: w_next_state = ST_SECONDS;
        default:    w_next_state = ST_RUN;
      endcase
    end else if (w_timeout) begin
      w_next_state = ST_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink: steady in RUN; in adjust states the phase restarts visible on
  // entry and on every increment so the field never vanishes while edited.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if ((w_next_state == ST_RUN) || (w_next_state != r_state) ||
                 w_inc_start || w_rep_pulse) begin
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
    end else if (w_tick) begin
      if (r_blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
        r_blink     <= ~r_blink;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign adjust_mode      = r_state;
  assign adjust_increment = r_inc_pulse;
  assign blink            = r_blink;
  assign adjusting        = r_adjusting;

endmodule

// File: tb/tb_adjust_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adjust_sequencer
//
// Self-checking bench for adjust_sequencer with small timing parameters.
// Drivers push the cycle numbers of expected strobes and mode changes into
// queues; a negedge monitor pops and compares them every cycle.
// -----------------------------------------------------------------------------
module tb_adjust_sequencer;

  localparam int TD = 4;   // TICK_DIV
  localparam int HT = 3;   // HOLD_TICKS
  localparam int RT = 2;   // REPEAT_TICKS
  localparam int TO = 20;  // TIMEOUT_TICKS
  localparam int BT = 2;   // BLINK_TICKS

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [2:0] adjust_mode;
  logic       adjust_increment;
  logic       blink;
  logic       adjusting;

  adjust_sequencer #(
    .TICK_DIV      (TD),
    .HOLD_TICKS    (HT),
    .REPEAT_TICKS  (RT),
    .TIMEOUT_TICKS (TO),
    .BLINK_TICKS   (BT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .btn_mode         (btn_mode),
    .btn_inc          (btn_inc),
    .adjust_mode      (adjust_mode),
    .adjust_increment (adjust_increment),
    .blink            (blink),
    .adjusting        (adjusting)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [2:0] m;
  } mode_ev_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;   // cycles since reset release; tick when cyc%TD == TD-1
  int         inc_q[$];      // cycles in which a strobe is expected
  mode_ev_t   mode_q[$];     // cycles in which adjust_mode takes a new value
  logic [2:0] model_mode;    // mode after all queued events
  logic [2:0] exp_mode;      // mode expected in the current cycle
  bit         mon_en  = 1'b0;
  bit         exp_inc;
  int         inc_seen = 0;
  int         last_mode_p;
  int         n_exp, seen0, p, q, te;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset_n === 1'b1 && mon_en) begin
      exp_inc = 1'b0;
      if (inc_q.size() > 0 && inc_q[0] == cyc) begin
        exp_inc = 1'b1;
        void'(inc_q.pop_front());
      end
      if (mode_q.size() > 0 && mode_q[0].c == cyc) begin
        exp_mode = mode_q[0].m;
        void'(mode_q.pop_front());
      end
      if (adjust_increment === 1'b1) inc_seen++;
      check("incr", adjust_increment, exp_inc);
      check("mode", adjust_mode, exp_mode);
      check("adjusting", adjusting, exp_mode != 3'b000);
    end
  end

  function automatic int nth_tick(input int start, input int n);
    int t;
    t = start + 1;
    while (t % TD != TD - 1) t++;
    return t + (n - 1) * TD;
  endfunction

  function automatic logic [2:0] adv(input logic [2:0] m);
    case (m)
      3'b000:  return 3'b100;
      3'b100:  return 3'b010;
      3'b010:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Blink phase in cycle c after entering a field at press cycle ent,
  // assuming no strobe since entry.
  function automatic logic blink_model(input int ent, input int c);
    int k;
    k = 0;
    for (int t = ent + 1; t < c; t++) if (t % TD == TD - 1) k++;
    return ((k / BT) % 2) == 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic queue_mode(input int c, input logic [2:0] m);
    mode_ev_t ev;
    ev.c = c;
    ev.m = m;
    mode_q.push_back(ev);
    model_mode = m;
  endtask

  task automatic press_mode(input int len);
    @(negedge clk);
    btn_mode    = 1'b1;
    last_mode_p = cyc;
    queue_mode(cyc + 1, adv(model_mode));
    repeat (len) @(negedge clk);
    btn_mode = 1'b0;
  endtask

  task automatic hold_inc(input int len, output int n_pulses);
    int ps, t;
    @(negedge clk);
    btn_inc  = 1'b1;
    ps       = cyc;
    n_pulses = 0;
    if (model_mode != 3'b000) begin
      inc_q.push_back(ps + 1);
      n_pulses = 1;
      t = nth_tick(ps, HT);
      while (t < ps + len) begin
        inc_q.push_back(t + 1);
        n_pulses++;
        t += RT * TD;
      end
    end
    repeat (len) @(negedge clk);
    btn_inc = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b1;
    btn_mode   = 1'b0;
    btn_inc    = 1'b0;
    model_mode = 3'b000;
    exp_mode   = 3'b000;
    #2 reset_n = 1'b0;
    #6;
    check("rst_mode", adjust_mode, 3'b000);
    check("rst_incr", adjust_increment, 1'b0);
    check("rst_blink", blink, 1'b1);
    check("rst_adjusting", adjusting, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Full mode cycle, no strobes.
    repeat (4) begin
      press_mode(2);
      idle(5);
    end

    // Inc held in RUN is ignored.
    hold_inc(15, n_exp);
    idle(3);

    // MINUTES: short inc press gives exactly one strobe, blink forced visible.
    press_mode(2);
    idle(2);
    press_mode(2);
    idle(10);
    @(negedge clk);
    check("t2_blink_before", blink, blink_model(last_mode_p, cyc));
    btn_inc = 1'b1;
    inc_q.push_back(cyc + 1);
    @(negedge clk);
    check("t2_blink_at_pulse", blink, 1'b1);
    repeat (2) @(negedge clk);
    btn_inc = 1'b0;
    idle(12);

    // HOURS: long hold with auto-repeat.
    press_mode(2);
    idle(2);
    press_mode(2);
    idle(2);
    press_mode(2);
    idle(3);
    seen0 = inc_seen;
    hold_inc(40, n_exp);
    idle(6);
    check("t3_pulse_count", inc_seen - seen0, n_exp);

    // Simultaneous mode + inc press in HOURS: mode wins, held inc stays dead.
    @(negedge clk);
    btn_mode    = 1'b1;
    btn_inc     = 1'b1;
    last_mode_p = cyc;
    queue_mode(cyc + 1, adv(model_mode));
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
    repeat (18) @(negedge clk);
    btn_inc = 1'b0;
    idle(2);
    hold_inc(3, n_exp);
    idle(4);

    // SECONDS with no activity: blink pattern, then timeout to RUN.
    press_mode(2);
    te = nth_tick(last_mode_p, TO);
    queue_mode(te + 1, 3'b000);
    while (cyc < te + 8) begin
      @(negedge clk);
      check("t5_blink", blink, (cyc > te) ? 1'b1 : blink_model(last_mode_p, cyc));
    end

    // Reset in the middle of an auto-repeat in MINUTES, buttons held across it.
    press_mode(2);
    idle(2);
    press_mode(2);
    idle(2);
    @(negedge clk);
    btn_inc = 1'b1;
    p = cyc;
    q = nth_tick(p, HT) + 1;
    inc_q.push_back(p + 1);
    inc_q.push_back(q);
    while (cyc != q) begin
      @(posedge clk);
      #1;
    end
    check("t6_pulse_pre_reset", adjust_increment, 1'b1);
    #1;
    reset_n  = 1'b0;
    btn_mode = 1'b1;
    inc_q.delete();
    mode_q.delete();
    model_mode = 3'b000;
    exp_mode   = 3'b000;
    #1;
    check("t6_rst_mode", adjust_mode, 3'b000);
    check("t6_rst_incr", adjust_increment, 1'b0);
    check("t6_rst_blink", blink, 1'b1);
    check("t6_rst_adjusting", adjusting, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(20);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    idle(2);
    press_mode(2);
    idle(2);
    hold_inc(3, n_exp);
    idle(5);

    check("inc_q_drained", inc_q.size(), 0);
    check("mode_q_drained", mode_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
